// File: rtl/riscv_multicycle_controller.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, ALU operation and write enables.
module riscv_multicycle_controller #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               N,
  input  logic               V,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] State
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    JAL      = STATE_W'(10)
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_dec;
  logic       taken;

  assign State = state_q;

  // State register; reset aborts any in-flight instruction back to fetch.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:     ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // ALU operation for R/I-type execute; sub only for R-type with funct7b5.
  always_comb begin
    alu_dec = 3'b000;
    case (funct3)
      3'b000: alu_dec = (op == OP_RTYPE && funct7b5) ? 3'b001 : 3'b000;
      3'b001: alu_dec = 3'b101;
      3'b010: alu_dec = 3'b111;
      3'b011: alu_dec = 3'b111;
      3'b100: alu_dec = 3'b100;
      3'b101: alu_dec = 3'b110;
      3'b110: alu_dec = 3'b011;
      3'b111: alu_dec = 3'b010;
    endcase
  end

  // Branch condition from the rs1-rs2 subtraction flags.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = N ^ V;
      3'b101:  taken = ~(N ^ V);
      default: taken = 1'b0;
    endcase
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_ITYPE:     state_d = EXECUTEI;
          OP_BRANCH:    state_d = BRANCH;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = taken;
        state_d    = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench for the multicycle controller: each scenario queues the
// expected per-cycle output vector and compares it as the FSM steps.
module tb_riscv_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, N, V;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic [19:0] obs;
  logic [19:0] e;
  logic [19:0] sb[$];
  int checks = 0;
  int failures = 0;

  riscv_multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .N(N), .V(V), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  // Packs one cycle of expected outputs in the same order as obs.
  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, mw, rw, irw, adr,
                                     input logic [1:0] rs, sa, sbb,
                                     input logic [2:0] alu, input logic [1:0] imm);
    return {st, pcw, mw, rw, irw, adr, rs, sa, sbb, alu, imm};
  endfunction

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, n, v);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; N = n; V = v;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00)) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs, mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    end
    reset = 1'b0;
  endtask

  task automatic test_lw;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    sb.push_back(mk(4'd4, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL lw state=%0d got=%h exp=%h", State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw;
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01));
    sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01));
    sb.push_back(mk(4'd5, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL sw state=%0d got=%h exp=%h", State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic exec_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0110011, f3, f7, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu,    2'b00));
    sb.push_back(mk(4'd8, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL rtype f3=%b f7=%b state=%0d got=%h exp=%h", f3, f7, State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic exec_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    set_instr(7'b0010011, f3, f7, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu,    2'b00));
    sb.push_back(mk(4'd8, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL itype f3=%b f7=%b state=%0d got=%h exp=%h", f3, f7, State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic exec_branch(input logic [2:0] f3, input logic z, n, v, input logic tk);
    set_instr(7'b1100011, f3, 1'b0, z, n, v);
    sb.push_back(mk(4'd0, 1,  0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b10));
    sb.push_back(mk(4'd1, 0,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10));
    sb.push_back(mk(4'd9, tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL branch f3=%b znv=%b%b%b state=%0d got=%h exp=%h", f3, z, n, v, State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal;
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0,  1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b11));
    sb.push_back(mk(4'd1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11));
    sb.push_back(mk(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11));
    sb.push_back(mk(4'd8,  0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL jal state=%0d got=%h exp=%h", State, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    set_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL illegal state=%0d got=%h exp=%h", State, obs, e); end
      if (sb.size() != 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_abort;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    sb.push_back(mk(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00));
    sb.push_back(mk(4'd3, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00));
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    while (sb.size() != 0) begin
      e = sb.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL abort state=%0d got=%h exp=%h", State, obs, e); end
      if (State == 4'd3) reset = 1'b1;
      if (sb.size() != 0) begin @(posedge clk); #1; end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    exec_r(3'b111, 1'b0, 3'b010);
    exec_i(3'b110, 1'b0, 3'b011);
    test_sw;
    exec_branch(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    exec_r(3'b001, 1'b0, 3'b101);
    exec_i(3'b100, 1'b0, 3'b100);
    exec_r(3'b011, 1'b0, 3'b111);
    exec_branch(3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
    exec_branch(3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
    exec_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    exec_branch(3'b101, 1'b0, 1'b1, 1'b1, 1'b1);
    test_lw;
    test_jal;
    set_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00));
    e = sb.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_end state=%0d got=%h exp=%h", State, obs, e); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sw;
    exec_r(3'b000, 1'b1, 3'b001);
    exec_r(3'b000, 1'b0, 3'b000);
    exec_i(3'b000, 1'b1, 3'b000);
    exec_r(3'b010, 1'b0, 3'b111);
    exec_i(3'b101, 1'b1, 3'b110);
    exec_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    exec_branch(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    exec_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    exec_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
    exec_branch(3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
    test_jal;
    test_illegal;
    test_reset_abort;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
